// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for MIPS DIV/DIVU
//
// Purpose: WIDTH-cycle restoring division. The result is {remainder, quotient}
// for the HI/LO write path. EX holds start_i high until it consumes the result,
// and annul_i aborts an in-flight division.
// Optional feature macro: DIV_EARLY_OUT_EN. When defined, the divider completes
// in one edge if |dividend| < |divisor|.
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous active-high reset
//   start_i      - division request, held until the result is consumed
//   annul_i      - flush: abort the current division and block new starts
//   signed_div_i - 1 = DIV (two's complement), 0 = DIVU
//   opdata1_i    - dividend
//   opdata2_i    - divisor
//   result_o     - {remainder, quotient}
//   ready_o      - result valid
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  dvd;    // dividend magnitude, shifted out MSB-first; quotient bits shift in at the LSB
  logic [WIDTH-1:0]  dsr;    // divisor magnitude
  logic [WIDTH-1:0]  rem;    // partial remainder
  logic              sign1;  // dividend was negative (signed mode only)
  logic              sign2;  // divisor was negative (signed mode only)

  logic              neg1, neg2;
  logic [WIDTH-1:0]  mag1, mag2;
  logic [WIDTH:0]    rem_sh;
  logic [WIDTH-1:0]  diff;
  logic              under;
  logic [WIDTH-1:0]  q_next, r_next, q_fix, r_fix;

  always_comb begin
    neg1 = signed_div_i & opdata1_i[WIDTH-1];
    neg2 = signed_div_i & opdata2_i[WIDTH-1];
    mag1 = neg1 ? (~opdata1_i + 1'b1) : opdata1_i;
    mag2 = neg2 ? (~opdata2_i + 1'b1) : opdata2_i;

    // One restoring step on the W+1-bit window {rem, next dividend bit}.
    rem_sh = {rem, dvd[WIDTH-1]};
    under  = rem_sh < {1'b0, dsr};
    // When the trial subtraction succeeds, the difference is below dsr and fits in WIDTH bits.
    diff   = rem_sh[WIDTH-1:0] - dsr;
    r_next = under ? rem_sh[WIDTH-1:0] : diff;
    q_next = {dvd[WIDTH-2:0], ~under};

    // Sign fix-up: the quotient is negative iff the signs differ, and the remainder follows the dividend.
    q_fix  = (sign1 ^ sign2) ? (~q_next + 1'b1) : q_next;
    r_fix  = sign1 ? (~r_next + 1'b1) : r_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      rem      <= '0;
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          result_o <= '0;
          ready_o  <= 1'b0;
          if (start_i && !annul_i) begin
            dvd   <= mag1;
            dsr   <= mag2;
            rem   <= '0;
            sign1 <= neg1;
            sign2 <= neg2;
            cnt   <= '0;
            if (opdata2_i == '0) begin
              state <= BYZERO;
`ifdef DIV_EARLY_OUT_EN
            end else if (mag1 < mag2) begin
              // The quotient is zero and the remainder is the untouched dividend.
              state    <= END;
              result_o <= {opdata1_i, {WIDTH{1'b0}}};
              ready_o  <= 1'b1;
`endif
            end else begin
              state <= ON;
            end
          end
        end
        BYZERO: begin
          state    <= END;
          dvd      <= '0;
          result_o <= '0;
          ready_o  <= 1'b1;
        end
        ON: begin
          if (annul_i) begin
            state    <= FREE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end else begin
            rem <= r_next;
            dvd <= q_next;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
              state    <= END;
              result_o <= {r_fix, q_fix};
              ready_o  <= 1'b1;
            end
          end
        end
        END: begin
          if (annul_i || !start_i) begin
            state    <= FREE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        default: begin
          state    <= FREE;
          result_o <= '0;
          ready_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking randomized testbench for div_unit
module tb_div_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, annul, sgn;
  logic [W-1:0]  a, b;
  logic [2*W-1:0] result;
  logic          ready;

  int tests = 0;
  int fails = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_i(start), .annul_i(annul),
    .signed_div_i(sgn), .opdata1_i(a), .opdata2_i(b),
    .result_o(result), .ready_o(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // MIPS semantics: truncating division, remainder takes dividend's sign, x/0 -> 0.
  function automatic logic [63:0] model(input logic s, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    if (y == 0) return 64'd0;
    sx = s ? longint'($signed(x)) : longint'({32'd0, x});
    sy = s ? longint'($signed(y)) : longint'({32'd0, y});
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int exp_lat(input logic s, input logic [31:0] x, input logic [31:0] y);
    longint ax, ay;
    if (y == 0) return 2;
    ax = s ? longint'($signed(x)) : longint'({32'd0, x});
    ay = s ? longint'($signed(y)) : longint'({32'd0, y});
    if (ax < 0) ax = -ax;
    if (ay < 0) ay = -ay;
`ifdef DIV_EARLY_OUT_EN
    if (ax < ay) return 1;
`endif
    return W + 1;
  endfunction

  task automatic run_div(input string tag, input logic s, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] exp;
    int n;
    exp = model(s, x, y);
    @(negedge clk);
    sgn = s; a = x; b = y; start = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      if (n == 1) begin
        #1;
        a = $urandom; b = $urandom; sgn = 1'($urandom);
      end
      @(negedge clk);
    end while (!ready && n < 100);
    check($sformatf("%s latency", tag), 64'(n), 64'(exp_lat(s, x, y)));
    check($sformatf("%s result", tag), result, exp);
    repeat (2) @(negedge clk);
    check($sformatf("%s held", tag), {63'd0, ready} ^ result, exp ^ 64'd1);
    start = 1'b0;
    @(negedge clk);
    check($sformatf("%s release", tag), {63'd0, ready} | result, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; annul = 1'b0; sgn = 1'b0; a = '0; b = '0;
    #1;
    check("reset ready", {63'd0, ready}, 64'd0);
    check("reset result", result, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_div("divu 100/7", 1'b0, 32'd100, 32'd7);
    run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    run_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1);
    run_div("divu 5/0", 1'b0, 32'd5, 32'd0);
    run_div("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0);
    run_div("divu 3/10", 1'b0, 32'd3, 32'd10);
    run_div("div -3/10", 1'b1, 32'hFFFF_FFFD, 32'd10);

    // Annul mid-division, then hold start and annul high together: nothing may start.
    @(negedge clk);
    sgn = 1'b0; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    check("annul out", {63'd0, ready} | result, 64'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (ready) seen++;
      end
      check("annul blocks start", 64'(seen), 64'd0);
    end
    start = 1'b0; annul = 1'b0;
    run_div("divu 9/3 after annul", 1'b0, 32'd9, 32'd3);

    // Asynchronous reset while ON, and again while a result is held in END.
    @(negedge clk);
    sgn = 1'b0; a = 32'd50; b = 32'd7; start = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rst mid-on", {63'd0, ready} | result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    a = 32'd100; b = 32'd7; start = 1'b1;
    begin
      int n = 0;
      while (!ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("pre-rst result", result, model(1'b0, 32'd100, 32'd7));
    end
    #2 rst = 1'b1;
    #1 check("rst in end", {63'd0, ready} | result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      logic s;
      logic [31:0] x, y;
      s = 1'($urandom);
      x = $urandom;
      case ($urandom % 5)
        0: y = 32'd0;
        1: y = $urandom_range(15, 1);
        2: y = 32'hFFFF_FFFF;
        3: y = x + 32'($urandom_range(3, 0));
        default: y = $urandom;
      endcase
      if ($urandom % 8 == 0) x = 32'h8000_0000;
      run_div($sformatf("rand%0d", i), s, x, y);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider for MIPS DIV/DIVU.
- Sits in EX, directly upstream of the HI/LO register write path.
- Produces a 2*WIDTH result {remainder, quotient}: remainder is written to HI, quotient to LO.
- Stalls the pipeline via `ready_o` handshake; can be annulled on a pipeline flush.

Parameters:
- WIDTH, 32, operand width in bits. Iteration count equals WIDTH. Counter width is clog2(WIDTH)+1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start_i  input  1  request division; held high by EX until the result is consumed.
- annul_i  input  1  flush: abort an in-flight division and block new starts.
- signed_div_i  input  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  input  WIDTH  dividend.
- opdata2_i  input  WIDTH  divisor.
- result_o  output  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}.
- ready_o  output  1  result valid.

Behaviour:
- Reset (async, any state): state=FREE; result_o=0; ready_o=0; counter=0; all internal operand/partial-remainder registers are 0.
- States: FREE, BYZERO, ON, END. All outputs are registered.
- FREE:
  - If start_i=1 and annul_i=0: latch opdata1_i, opdata2_i and signed_div_i.
  - If the divisor is 0, go to BYZERO. Otherwise go to ON with counter=0.
  - With signed_div_i=1, latch magnitudes (negate negative operands) and record both sign bits.
  - Otherwise stay in FREE with ready_o=0 and result_o=0.
- BYZERO: next edge goes to END with quotient=0 and remainder=0. The dividend is not preserved.
- ON, per edge:
  - If annul_i=1: go to FREE with result_o=0. No ready pulse.
  - Else perform one restoring step:
    - Shift {partial_rem, dividend} left by 1.
    - Trial-subtract the divisor from the upper W+1 bits.
    - If the difference is non-negative, keep it and set quotient LSB=1. Otherwise restore and set it to 0.
  - Increment the counter. On the edge completing step WIDTH, go to END.
- Sign fix-up, applied on the transition into END (signed only):
  - Negate the quotient iff the dividend and divisor signs differ.
  - The remainder takes the sign of the dividend.
  - 0x80000000 / -1 gives quotient 0x80000000, remainder 0. No trap.
- END:
  - result_o holds the final value and ready_o=1.
  - While start_i=1, stay in END with the outputs held.
  - When start_i=0, the next edge goes to FREE with ready_o=0 and result_o=0.
  - annul_i in END forces FREE on the next edge.
- Latency (normal): call the edge sampling start_i=1 in FREE edge 1. ready_o rises after edge WIDTH+1, i.e. edge 33 for WIDTH=32.
- Latency (divide-by-zero): ready_o rises after edge 2.
- Operand changes on opdata*_i after edge 1 have no effect.
- start_i and annul_i high together in FREE: annul wins, no start.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - In FREE, if the divisor is non-zero and |dividend| < |divisor| (unsigned compare of the latched magnitudes), skip ON entirely.
  - Go straight to END on edge 1 with quotient=0 and remainder=original dividend (sign preserved).
  - ready_o rises after edge 1.
- Undefined: this case takes the full WIDTH+1 edges; the result is identical.

Test Plan:
- DIVU 100/7, start held -> ready_o high after edge 33; result_o={32'd2, 32'd14}; result stays held while start_i=1. Drop start_i -> ready_o=0 and result_o=0 next edge.
- DIV -7/2 (0xFFFFFFF9/0x2) -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). DIV 7/-2 -> quotient -3, remainder 1.
- DIV 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0. DIVU 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
- Divisor 0 (DIVU 5/0) -> ready_o high after edge 2, result_o=0.
- Annul at iteration 10 of DIVU 1000/3 -> state FREE next edge, ready_o never asserts. A new DIVU 9/3 then gives {0, 3} after 33 edges. Assert rst mid-ON -> all outputs 0 immediately.
- DIVU 3/10: with DIV_EARLY_OUT_EN -> ready after edge 1, result {3, 0}; without it -> ready after edge 33, same result.
